synth_result_drain: RTL

- Downstream consumer of the synth_core result register.
- Captures each valid 32-bit result into a small show-ahead FIFO and releases it over a valid/ready interface to the next stage.
- Maintains a running rotate-XOR signature and an accepted-word count for checking.
- The core cannot stall, so the drain never back-pressures its input. Words arriving when the FIFO is full are dropped and flagged.

---
 rtl/synth_result_drain_if.sv | 20 ++
 rtl/synth_result_drain.sv | 71 +++++++
 2 files changed

// File: rtl/synth_result_drain_if.sv
// synth_result_drain_if: result-word input and valid/ready output channel of the drain.
interface synth_result_drain_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/synth_result_drain.sv
// synth_result_drain: show-ahead FIFO that drains core results to a valid/ready consumer,
// keeping a rotate-XOR signature, a saturating accepted-word count and a sticky overflow flag.
module synth_result_drain #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    synth_result_drain_if.slave      bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DATA_W-1:0]        sig,
    output logic [CNT_W-1:0]         count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full, pop, push, drop;

    assign full = level_q == LW'(DEPTH);
    assign pop  = bus.out_valid & bus.out_ready;
    // The core cannot stall, so a full FIFO only takes a word if a pop frees the slot.
    assign push = bus.in_valid & (!full | pop);
    assign drop = bus.in_valid & full & !pop;

    always_comb begin
        rd_d    = clr ? '0 : pop ? rd_q + AW'(1) : rd_q;
        wr_d    = clr ? '0 : push ? wr_q + AW'(1) : wr_q;
        level_d = clr ? '0 : (push & !pop) ? level_q + LW'(1) : (pop & !push) ? level_q - LW'(1) : level_q;
        sig_d   = clr ? '0 : push ? {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ bus.in_data : sig_q;
        count_d = clr ? '0 : (push & ~&count_q) ? count_q + CNT_W'(1) : count_q;
        ovf_d   = !clr & (ovf_q | drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            sig_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push & !clr) mem_q[wr_q] <= bus.in_data;
    end

    assign bus.out_valid = level_q != '0;
    assign bus.out_data  = mem_q[rd_q];
    assign level         = level_q;
    assign sig           = sig_q;
    assign count         = count_q;
    assign overflow      = ovf_q;
endmodule
